// File: rtl/fc_argmax.sv
// Purpose : 2-class fully-connected classifier over the 8-entry flatten bank, with argmax output.
// Latency : busy for 26 cycles (24 reads + drain + decide); done pulses on the first idle cycle after.
// Backpr. : none; start is ignored while busy, and memory data must arrive exactly 1 cycle after crd.
module fc_argmax #(
   parameter int         N_FEAT   = 8,
   parameter int         N_CLASS  = 2,
   parameter logic [2:0] FEAT_SEL = 3'b101,
   parameter logic [2:0] WGT_SEL  = 3'b110
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        crd,
   output logic [3:0]  caddr_rd,
   output logic [2:0]  csel,
   input  logic [4:0]  cdata_rd,
   output logic [12:0] score0,
   output logic [12:0] score1,
   output logic        class_id,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DECIDE} state_t;

   // Issue phase within one feature: 0 = feature, 1 = class-0 weight, 2 = class-1 weight.
   localparam logic [1:0] PH_FEAT = 2'd0;
   localparam logic [1:0] PH_W0   = 2'd1;
   localparam logic [1:0] PH_W1   = 2'd2;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [1:0]         phase_q, phase_d;
   logic [3:0]         caddr_q, caddr_d;
   logic [2:0]         csel_q, csel_d;
   logic               cap_vld_q, cap_vld_d;
   logic [1:0]         cap_phase_q, cap_phase_d;
   logic [4:0]         feat_q, feat_d;
   logic signed [12:0] acc0_q, acc0_d;
   logic signed [12:0] acc1_q, acc1_d;
   logic signed [12:0] score0_q, score0_d;
   logic signed [12:0] score1_q, score1_d;
   logic               class_q, class_d;
   logic               done_q, done_d;
   logic signed [10:0] prod;
   logic signed [12:0] prod_ext;
   logic               last_issue;

   // Unsigned feature times signed weight; the exact result always fits in 11 signed bits.
   always_comb begin
      prod     = $signed({6'b0, feat_q}) * $signed({{6{cdata_rd[4]}}, cdata_rd});
      prod_ext = {{2{prod[10]}}, prod};
   end

   // Next-state, read sequencing, data capture and result registration.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      phase_d     = phase_q;
      caddr_d     = caddr_q;
      csel_d      = csel_q;
      cap_vld_d   = 1'b0;
      cap_phase_d = cap_phase_q;
      feat_d      = feat_q;
      acc0_d      = acc0_q;
      acc1_d      = acc1_q;
      score0_d    = score0_q;
      score1_d    = score1_q;
      class_d     = class_q;
      done_d      = 1'b0;
      last_issue  = (idx_q == 3'(N_FEAT - 1)) && (phase_q == PH_W1);

      // Data returned for the previous cycle's issue.
      if (cap_vld_q) begin
         case (cap_phase_q)
            PH_FEAT: feat_d = cdata_rd;
            PH_W0:   acc0_d = acc0_q + prod_ext;
            PH_W1:   acc1_d = acc1_q + prod_ext;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               idx_d   = 3'd0;
               phase_d = PH_FEAT;
               csel_d  = FEAT_SEL;
               caddr_d = 4'd0;
               acc0_d  = '0;
               acc1_d  = '0;
            end
         end
         READ: begin
            cap_vld_d   = 1'b1;
            cap_phase_d = phase_q;
            if (last_issue) begin
               // Address/select hold their final values once the strobe drops.
               state_d = DRAIN;
            end else begin
               if (phase_q == PH_W1) begin
                  phase_d = PH_FEAT;
                  idx_d   = idx_q + 3'd1;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
               csel_d  = (phase_d == PH_FEAT) ? FEAT_SEL : WGT_SEL;
               caddr_d = (phase_d == PH_W1) ? (4'(N_FEAT) + {1'b0, idx_d}) : {1'b0, idx_d};
            end
         end
         DRAIN: begin
            state_d = DECIDE;
         end
         DECIDE: begin
            score0_d = acc0_q;
            score1_d = acc1_q;
            class_d  = (acc1_q > acc0_q);
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset clearing everything visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         phase_q     <= '0;
         caddr_q     <= '0;
         csel_q      <= '0;
         cap_vld_q   <= 1'b0;
         cap_phase_q <= '0;
         feat_q      <= '0;
         acc0_q      <= '0;
         acc1_q      <= '0;
         score0_q    <= '0;
         score1_q    <= '0;
         class_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         caddr_q     <= caddr_d;
         csel_q      <= csel_d;
         cap_vld_q   <= cap_vld_d;
         cap_phase_q <= cap_phase_d;
         feat_q      <= feat_d;
         acc0_q      <= acc0_d;
         acc1_q      <= acc1_d;
         score0_q    <= score0_d;
         score1_q    <= score1_d;
         class_q     <= class_d;
         done_q      <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign crd      = (state_q == READ);
   assign caddr_rd = caddr_q;
   assign csel     = csel_q;
   assign score0   = score0_q;
   assign score1   = score1_q;
   assign class_id = class_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Purpose : self-checking bench for fc_argmax with a 1-cycle-latency memory model.
// Latency : each classification is observed over a bounded window of cycles.
// Backpr. : n/a; the memory model always answers the cycle after a read strobe.
module tb_fc_argmax;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, crd, class_id, done;
   logic [3:0]  caddr_rd;
   logic [2:0]  csel;
   logic [4:0]  cdata_rd = 5'd0;
   logic [12:0] score0, score1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] feat_m [8];
   logic [4:0] wgt_m  [16];

   typedef struct packed {
      logic [7:0][4:0]  f;
      logic [15:0][4:0] w;
      int               s0;
      int               s1;
      int               cls;
   } vec_t;

   vec_t tbl [12];

   fc_argmax dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .crd(crd),
      .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
      .score0(score0), .score1(score1), .class_id(class_id), .done(done)
   );

   always #5 clk = ~clk;

   // Memory: data for a strobed read appears one cycle later.
   always @(posedge clk) begin
      if (crd) begin
         if (csel == 3'b101)      cdata_rd <= feat_m[caddr_rd[2:0]];
         else if (csel == 3'b110) cdata_rd <= wgt_m[caddr_rd];
         else                     cdata_rd <= 5'd0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain dot products and a strict greater-than for the argmax.
   function automatic void model(input vec_t v, output int s0, output int s1, output int c);
      s0 = 0;
      s1 = 0;
      for (int i = 0; i < 8; i++) begin
         s0 += int'(v.f[i]) * int'($signed(v.w[i]));
         s1 += int'(v.f[i]) * int'($signed(v.w[8 + i]));
      end
      c = (s1 > s0) ? 1 : 0;
   endfunction

   task automatic load(input vec_t v);
      for (int i = 0; i < 8; i++)  feat_m[i] = v.f[i];
      for (int i = 0; i < 16; i++) wgt_m[i]  = v.w[i];
   endtask

   function automatic int sc(input logic [12:0] s);
      return int'($signed(s));
   endfunction

   // One classification from idle; optionally re-pulses start on busy cycle 5.
   task automatic run_one(input string tag, input int es0, input int es1, input int ec, input bit repulse);
      int bc = 0, dcnt = 0, last_busy = -1, done_cyc = -1;
      int crd_bad = 0, issue_bad = 0, nissue = 0;
      int gs0 = 0, gs1 = 0, gc = 0;
      int ecsel, eaddr;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (busy) begin
            bc++;
            last_busy = c;
            if (crd !== (bc <= 24)) crd_bad++;
         end else if (crd) crd_bad++;
         if (crd) begin
            ecsel = (nissue % 3 == 0) ? 5 : 6;
            eaddr = (nissue % 3 == 2) ? 8 + nissue / 3 : nissue / 3;
            if (int'(csel) != ecsel || int'(caddr_rd) != eaddr) begin
               if (issue_bad == 0)
                  $display("FAIL %s issue %0d: got (%0d,%0d), expected (%0d,%0d)",
                           tag, nissue, csel, caddr_rd, ecsel, eaddr);
               issue_bad++;
            end
            nissue++;
         end
         if (done) begin
            if (done_cyc < 0) begin
               done_cyc = c;
               gs0 = sc(score0);
               gs1 = sc(score1);
               gc  = int'(class_id);
            end
            dcnt++;
         end
         if (repulse) start = (bc == 5);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, " busy_cycles"}, bc, 26);
      chk({tag, " done_count"}, dcnt, 1);
      chk({tag, " done_timing"}, done_cyc, last_busy + 1);
      chk({tag, " crd_pattern_errs"}, crd_bad, 0);
      chk({tag, " issue_count"}, nissue, 24);
      chk({tag, " issue_order_errs"}, issue_bad, 0);
      chk({tag, " score0"}, gs0, es0);
      chk({tag, " score1"}, gs1, es1);
      chk({tag, " class_id"}, gc, ec);
      chk({tag, " score0_hold"}, sc(score0), es0);
   endtask

   initial begin
      int s0, s1, c, guard;

      // Table: three fixed cases with hand-computed results, then model-checked ones.
      for (int i = 0; i < 8; i++) begin
         tbl[0].f[i] = 5'd1;  tbl[0].w[i] = 5'd1;  tbl[0].w[8+i] = 5'd2;
         tbl[1].f[i] = 5'd3;  tbl[1].w[i] = 5'd5;  tbl[1].w[8+i] = 5'd5;
         tbl[2].f[i] = 5'd31; tbl[2].w[i] = 5'h10; tbl[2].w[8+i] = 5'd15;
         tbl[3].f[i] = 5'd31; tbl[3].w[i] = (i % 2 == 0) ? 5'd15 : 5'h10;
         tbl[3].w[8+i] = 5'($urandom_range(0, 31));
      end
      tbl[0].s0 = 8;     tbl[0].s1 = 16;   tbl[0].cls = 1;
      tbl[1].s0 = 120;   tbl[1].s1 = 120;  tbl[1].cls = 0;
      tbl[2].s0 = -3968; tbl[2].s1 = 3720; tbl[2].cls = 1;
      for (int k = 4; k < 12; k++)
         for (int i = 0; i < 8; i++) begin
            tbl[k].f[i]   = 5'($urandom_range(0, 31));
            tbl[k].w[i]   = 5'($urandom_range(0, 31));
            tbl[k].w[8+i] = 5'($urandom_range(0, 31));
         end
      for (int k = 3; k < 12; k++) begin
         model(tbl[k], s0, s1, c);
         tbl[k].s0 = s0; tbl[k].s1 = s1; tbl[k].cls = c;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst busy", int'(busy), 0);
      chk("rst crd", int'(crd), 0);
      chk("rst csel", int'(csel), 0);
      chk("rst caddr", int'(caddr_rd), 0);
      chk("rst score0", sc(score0), 0);
      chk("rst score1", sc(score1), 0);
      chk("rst class", int'(class_id), 0);
      chk("rst done", int'(done), 0);

      for (int k = 0; k < 12; k++) begin
         load(tbl[k]);
         run_one($sformatf("vec%0d", k), tbl[k].s0, tbl[k].s1, tbl[k].cls, 1'b0);
      end

      // Start re-pulsed mid-run must not restart.
      load(tbl[1]);
      run_one("repulse", tbl[1].s0, tbl[1].s1, tbl[1].cls, 1'b1);

      // Reset mid-run: outputs zero next cycle, no done afterwards.
      load(tbl[0]);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrst busy_before", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      chk("midrst busy", int'(busy), 0);
      chk("midrst crd", int'(crd), 0);
      chk("midrst score0", sc(score0), 0);
      chk("midrst score1", sc(score1), 0);
      chk("midrst csel", int'(csel), 0);
      guard = 0;
      for (int c2 = 0; c2 < 30; c2++) begin
         if (done || busy) guard++;
         @(negedge clk);
      end
      chk("midrst no_activity", guard, 0);
      run_one("after_rst", 8, 16, 1, 1'b0);

      // Start held through completion launches the next run on the done cycle.
      load(tbl[2]);
      @(negedge clk) start = 1'b1;
      guard = 0;
      while (!done && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("hold done_seen", int'(done), 1);
      @(negedge clk);
      chk("hold restart_busy", int'(busy), 1);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("hold second_done", int'(done), 1);
      chk("hold score0", sc(score0), -3968);
      chk("hold score1", sc(score1), 3720);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Classifier stage directly downstream of the CONV block.
- Consumes the 8-entry flattened layer-2 output (bank csel=3'b101) and computes a 2-class fully-connected dot product against a 16-entry weight bank (csel=3'b110).
- Registers both class scores and the argmax class index.
- Shares the same single-read-port memory protocol as CONV: crd/caddr_rd/csel out, cdata_rd in.

Parameters:
- N_FEAT, 8, number of flattened features; fixed by the layer-2 size.
- N_CLASS, 2, number of output classes. Weight bank holds N_FEAT*N_CLASS entries and must fit the 4-bit address.
- FEAT_SEL, 3'b101, csel value selecting the flatten bank.
- WGT_SEL, 3'b110, csel value selecting the weight bank.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- start  in  1  begin one classification; sampled only while idle.
- busy  out  1  high while the operation is in progress.
- crd  out  1  memory read strobe.
- caddr_rd  out  4  memory read address.
- csel  out  3  memory bank select.
- cdata_rd  in  5  read data, valid in the cycle after crd is asserted (1-cycle latency).
- score0  out  13  signed class-0 score.
- score1  out  13  signed class-1 score.
- class_id  out  1  argmax result.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0 (busy, crd, caddr_rd, csel, score0, score1, class_id, done). FSM goes to IDLE; accumulators are cleared.
- FSM states: IDLE -> READ -> DRAIN -> DECIDE -> IDLE.
- IDLE:
  - start=1 at a posedge -> READ; busy=1 from the next cycle.
  - Entering READ clears the accumulators; score0, score1 and class_id keep their previous values until DECIDE.
- READ: lasts exactly 24 cycles with crd=1. Issue order for i=0..7:
  - (csel=FEAT_SEL, addr=i)
  - (csel=WGT_SEL, addr=i)
  - (csel=WGT_SEL, addr=8+i)
- Data capture:
  - cdata_rd is captured the cycle after each issue.
  - Feature i is unsigned 0..31. Weight w0[i] is at address i, w1[i] at address 8+i; both are signed two's complement, -16..15.
  - On capture of w0[i]: acc0 += feat_i*w0[i]. On capture of w1[i]: acc1 += feat_i*w1[i].
  - Each product is 11-bit signed; each accumulator is 13-bit signed. Range -3968..3720, so no saturation or overflow handling is needed.
- DRAIN: 1 cycle, crd=0; captures the last w1[7] data.
- DECIDE: 1 cycle.
  - Registers score0=acc0, score1=acc1.
  - class_id = (acc1 > acc0) ? 1 : 0; ties resolve to class 0.
  - Next state is IDLE.
- Timing:
  - busy is high for exactly 26 cycles (24 READ + 1 DRAIN + 1 DECIDE).
  - done=1 for exactly one cycle: the first cycle busy=0 after DECIDE.
  - score0, score1 and class_id are valid when done=1 and held until the next DECIDE.
- When crd=0, caddr_rd and csel hold their last values; consumers must ignore them.
- start while busy=1 is ignored. No queuing; no effect on the in-flight run.
- start held high through completion starts a new run from IDLE on the cycle done is asserted.
- reset mid-operation:
  - Next cycle: busy=0, crd=0, FSM=IDLE, all outputs zeroed.
  - No done pulse is generated.
- The block never writes memory (no cwr).

Test Plan:
1. Basic: all features=1, w0[*]=1, w1[*]=2, pulse start -> busy high 26 cycles; done pulse; score0=8, score1=16, class_id=1.
2. Read protocol: monitor crd cycles -> exactly 24 issues in order (101,0),(110,0),(110,8),(101,1),(110,1),(110,9)...(110,15); no gaps.
3. Tie: features=3, w0=w1=5 -> score0=score1=120, class_id=0.
4. Extremes: features=31, w0[*]=-16, w1[*]=15 -> score0=-3968 (13'h1080), score1=3720, class_id=1. Mixed-sign w0={15,-16,...} checked against a reference model.
5. Robustness: start re-pulsed at busy cycle 5 -> no restart, still 26 busy cycles. Reset asserted at busy cycle 10 -> next cycle busy=0, crd=0, scores 0, no done; subsequent start completes correctly with case-1 data.
